// File: rtl/fifo_wr_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_wr_arb : round-robin multi-requester write arbiter for a FIFO memory |
// | FIFO_ARB_PKT_LOCK_EN holds the grant for a whole packet.  Rev 1.0         |
// +--------------------------------------------------------------------------+
module fifo_wr_arb #(
   parameter int NUM_REQ   = 4,
   parameter int DATASIZE  = 8,
   parameter int ADDRSIZE  = 9,
   parameter int DEPTH     = 444,
   parameter int MAX_BURST = 4
) (
   input  logic                         wclk,
   input  logic                         wrst,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ*DATASIZE-1:0]  req_data,
   input  logic [NUM_REQ-1:0]           req_last,
   output logic [NUM_REQ-1:0]           gnt,
   input  logic                         wfull,
   output logic                         winc,
   output logic [ADDRSIZE-1:0]          waddr,
   output logic [DATASIZE-1:0]          wdata,
   output logic [$clog2(NUM_REQ)-1:0]   owner
);

   localparam int c_ow = $clog2(NUM_REQ);
   localparam int c_cw = 5;
   localparam logic [ADDRSIZE-1:0] c_addr_last = ADDRSIZE'(DEPTH - 1);
`ifdef FIFO_ARB_PKT_LOCK_EN
   localparam bit c_lock = 1'b1;
`else
   localparam bit c_lock = 1'b0;
`endif

   typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} state_t;

   state_t              r_state,    w_state_nxt;
   logic [c_cw-1:0]     r_beat_cnt, w_cnt_nxt;
   logic [c_ow-1:0]     w_owner_nxt;
   logic [ADDRSIZE-1:0] w_waddr_nxt;
   logic [c_ow-1:0]     w_win;
   logic                w_found;
   logic                w_last;

   always_ff @(posedge wclk) begin
      if (wrst) begin
         r_state    <= IDLE;
         owner      <= c_ow'(NUM_REQ - 1);
         r_beat_cnt <= '0;
         waddr      <= '0;
      end else begin
         r_state    <= w_state_nxt;
         owner      <= w_owner_nxt;
         r_beat_cnt <= w_cnt_nxt;
         waddr      <= w_waddr_nxt;
      end
   end

   always_comb begin
      w_found     = 1'b0;
      w_win       = owner;
      gnt         = '0;
      wdata       = '0;
      w_state_nxt = r_state;
      w_owner_nxt = owner;
      w_cnt_nxt   = r_beat_cnt;
      w_waddr_nxt = waddr;

      // BURST keeps the grant on the owner; IDLE searches from owner+1 with wrap.
      if (r_state == BURST) begin
         w_found = req[owner];
      end else begin
         for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
               if (!w_found && req[i] && (i == (int'(owner) + k) % NUM_REQ)) begin
                  w_found = 1'b1;
                  w_win   = c_ow'(i);
               end
            end
         end
      end

      for (int i = 0; i < NUM_REQ; i++) begin
         gnt[i] = w_found && !wrst && !wfull && (w_win == c_ow'(i));
         if (gnt[i] && req[i]) begin
            wdata = wdata | req_data[i*DATASIZE +: DATASIZE];
         end
      end
      winc   = |(req & gnt);
      w_last = |(req_last & gnt);

      if (winc) begin
         w_waddr_nxt = (waddr == c_addr_last) ? '0 : waddr + 1'b1;
         w_owner_nxt = w_win;
         if (r_state == IDLE) begin
            if (w_last || (!c_lock && MAX_BURST == 1)) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_state_nxt = BURST;
               w_cnt_nxt   = c_cw'(1);
            end
         end else begin
            w_cnt_nxt = r_beat_cnt + 1'b1;
            if (w_last || (!c_lock && w_cnt_nxt == c_cw'(MAX_BURST))) begin
               w_state_nxt = IDLE;
            end
         end
      end else if (r_state == BURST && !wfull && !c_lock) begin
         // Owner stopped offering beats: release the burst, this cycle grants nobody.
         w_state_nxt = IDLE;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fifo_wr_arb : directed self-checking bench for fifo_wr_arb. Rev 1.0    |
// +--------------------------------------------------------------------------+
module tb_fifo_wr_arb;

   logic        clk;
   logic        wrst;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  req_last;
   logic [3:0]  gnt;
   logic        wfull;
   logic        winc;
   logic [8:0]  waddr;
   logic [7:0]  wdata;
   logic [1:0]  owner;

   int n_total = 0;
   int n_bad   = 0;

   fifo_wr_arb #(
      .NUM_REQ  (4),
      .DATASIZE (8),
      .ADDRSIZE (9),
      .DEPTH    (444),
      .MAX_BURST(4)
   ) dut (
      .wclk    (clk),
      .wrst    (wrst),
      .req     (req),
      .req_data(req_data),
      .req_last(req_last),
      .gnt     (gnt),
      .wfull   (wfull),
      .winc    (winc),
      .waddr   (waddr),
      .wdata   (wdata),
      .owner   (owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      wrst = 1'b1; req = '0; req_last = '0; wfull = 1'b0;
      tick();
      req = 4'b1111; req_last = 4'b1111;
      #1;
      check_val("rst_gnt", {28'd0, gnt}, 32'd0);
      check_val("rst_winc", {31'd0, winc}, 32'd0);
      check_val("rst_wdata", {24'd0, wdata}, 32'd0);
      check_val("rst_owner", {30'd0, owner}, 32'd3);
      check_val("rst_waddr", {23'd0, waddr}, 32'd0);
      tick();
      wrst = 1'b0; req = '0; req_last = '0;
   endtask

   logic [3:0] rr_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
   logic [7:0] rr_dat [5] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
`ifdef FIFO_ARB_PKT_LOCK_EN
   localparam int PK_N = 8;
   logic [3:0] pk_gnt [PK_N] = '{4'h1, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h1};
   logic [3:0] wf_gnt [8]    = '{4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h2, 4'h2, 4'h2};
   logic [3:0] od_gnt [3]    = '{4'h2, 4'h0, 4'h0};
`else
   localparam int PK_N = 9;
   logic [3:0] pk_gnt [PK_N] = '{4'h1, 4'h4, 4'h4, 4'h4, 4'h4, 4'h1, 4'h4, 4'h4, 4'h1};
   logic [3:0] wf_gnt [8]    = '{4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h2, 4'h2, 4'h1};
   logic [3:0] od_gnt [3]    = '{4'h2, 4'h0, 4'h1};
`endif
   logic [8:0] wf_addr  [8] = '{9'd0, 9'd1, 9'd2, 9'd2, 9'd2, 9'd2, 9'd3, 9'd4};
   logic [1:0] wf_owner [8] = '{2'd3, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};

   initial begin
      int sent;
      wrst = 1'b1; req = '0; req_last = '0; wfull = 1'b0;
      req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

      // Round robin with single-beat packets from everyone.
      do_reset();
      req = 4'b1111; req_last = 4'b1111;
      for (int c = 0; c < 5; c++) begin
         #1;
         check_val("rr_gnt", {28'd0, gnt}, {28'd0, rr_gnt[c]});
         check_val("rr_waddr", {23'd0, waddr}, c);
         check_val("rr_wdata", {24'd0, wdata}, {24'd0, rr_dat[c]});
         tick();
      end

      // Six-beat packet on requester 2 competing with single beats on requester 0.
      do_reset();
      sent = 0;
      for (int c = 0; c < PK_N; c++) begin
         req      = {1'b0, (sent < 6), 1'b0, 1'b1};
         req_last = {1'b0, (sent == 5), 1'b0, 1'b1};
         #1;
         check_val("pk_gnt", {28'd0, gnt}, {28'd0, pk_gnt[c]});
         check_val("pk_waddr", {23'd0, waddr}, c);
         if (gnt[2] && req[2]) sent++;
         tick();
      end

      // Back-pressure in the middle of a burst from requester 1.
      do_reset();
      for (int c = 0; c < 8; c++) begin
         wfull    = (c >= 2 && c <= 4);
         req      = {2'b00, 1'b1, (c >= 6)};
         req_last = {3'b000, (c >= 6)};
         #1;
         check_val("wf_gnt", {28'd0, gnt}, {28'd0, wf_gnt[c]});
         check_val("wf_winc", {31'd0, winc}, {31'd0, |wf_gnt[c]});
         check_val("wf_waddr", {23'd0, waddr}, {23'd0, wf_addr[c]});
         check_val("wf_owner", {30'd0, owner}, {30'd0, wf_owner[c]});
         tick();
      end
      wfull = 1'b0;

      // Owner drops its request mid-burst.
      do_reset();
      for (int c = 0; c < 3; c++) begin
         req = (c == 0) ? 4'b0010 : 4'b0001;
         req_last = '0;
         #1;
         check_val("od_gnt", {28'd0, gnt}, {28'd0, od_gnt[c]});
         check_val("od_winc", {31'd0, winc}, {31'd0, |od_gnt[c]});
         tick();
      end

      // Address wraps from DEPTH-1 back to zero under continuous writes.
      do_reset();
      req = 4'b0001; req_last = 4'b0001;
      for (int c = 0; c < 446; c++) begin
         #1;
         check_val("wrap_waddr", {23'd0, waddr}, c % 444);
         check_val("wrap_winc", {31'd0, winc}, 32'd1);
         tick();
      end

      // Reset after the second beat of a packet from requester 3.
      do_reset();
      req = 4'b1000; req_last = '0;
      for (int c = 0; c < 2; c++) begin
         #1;
         check_val("mr_gnt", {28'd0, gnt}, 32'h8);
         check_val("mr_waddr", {23'd0, waddr}, c);
         tick();
      end
      wrst = 1'b1;
      #1;
      check_val("mr_rst_gnt", {28'd0, gnt}, 32'd0);
      check_val("mr_rst_winc", {31'd0, winc}, 32'd0);
      tick();
      wrst = 1'b0; req = 4'b1001; req_last = 4'b1001;
      #1;
      check_val("mr_post_gnt", {28'd0, gnt}, 32'h1);
      check_val("mr_post_waddr", {23'd0, waddr}, 32'd0);
      check_val("mr_post_owner", {30'd0, owner}, 32'd3);
      tick();
      #1;
      check_val("mr_next_gnt", {28'd0, gnt}, 32'h8);
      check_val("mr_next_waddr", {23'd0, waddr}, 32'd1);
      tick();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter DATASIZE, default 8, giving the memory data word width.
REQ-003 The block SHALL have parameter ADDRSIZE, default 9, giving the memory address width.
REQ-004 The block SHALL have parameter DEPTH, default 444, giving the number of memory words (2..2^ADDRSIZE, not necessarily a power of two).
REQ-005 The block SHALL have parameter MAX_BURST, default 4, giving the maximum beats per grant when packet lock is off (1..16).
REQ-006 wclk  input  1  write-side clock; the block's only clock, rising edge.
REQ-007 wrst  input  1  reset; synchronous, active-high.
REQ-008 req  input  NUM_REQ  per-requester beat valid.
REQ-009 req_data  input  NUM_REQ*DATASIZE  per-requester beat data; requester i occupies bits [i*DATASIZE +: DATASIZE].
REQ-010 req_last  input  NUM_REQ  per-requester last beat of packet, qualified by req.
REQ-011 gnt  output  NUM_REQ  one-hot beat accept; a beat from i transfers in any cycle with req[i] && gnt[i].
REQ-012 wfull  input  1  memory full flag from the write-side full logic.
REQ-013 winc  output  1  memory write enable.
REQ-014 waddr  output  ADDRSIZE  memory write address.
REQ-015 wdata  output  DATASIZE  memory write data.
REQ-016 owner  output  $clog2(NUM_REQ)  index of current or last grant holder.

Function
REQ-017 gnt, winc and wdata SHALL be combinational from req, req_last, wfull and registered state: zero-cycle accept-to-write latency.
REQ-018 gnt SHALL be all-zero whenever wfull=1 or wrst=1; at most one gnt bit SHALL be set in any cycle.
REQ-019 winc SHALL equal |(req & gnt); wdata SHALL equal the granted requester's req_data slice, and all-zero when winc=0.
REQ-020 The FSM SHALL have states IDLE and BURST.
REQ-021 In IDLE, the block SHALL grant the first requester with req=1 searching round-robin from (owner+1) mod NUM_REQ upward with wrap.
REQ-022 In IDLE, on an accepted beat with req_last=1, or with MAX_BURST=1 and packet lock off, the FSM SHALL stay in IDLE and owner SHALL become the winner.
REQ-023 In IDLE, on any other accepted beat, the FSM SHALL go to BURST, set owner to the winner, and set beat_cnt to 1.
REQ-024 In BURST, gnt SHALL go only to owner; other requesters SHALL stall regardless of req.
REQ-025 In BURST, on an accepted beat, beat_cnt SHALL increment; the FSM SHALL return to IDLE on req_last=1 or on the release condition of REQ-037/038.
REQ-026 waddr SHALL increment by one on each cycle with winc=1, and SHALL wrap from DEPTH-1 to 0.
REQ-027 With wfull=1, the FSM, owner, beat_cnt and waddr SHALL hold.
REQ-028 A req drop without req_last SHALL NOT count as a beat.

Reset
REQ-029 When wrst=1 at a wclk edge, the block SHALL set state=IDLE, owner=NUM_REQ-1 (first search starts at 0), beat_cnt=0 and waddr=0.
REQ-030 Outputs during and after reset SHALL be gnt=0 and winc=0; wdata=0 follows from REQ-019.
REQ-031 Reset mid-BURST SHALL abandon the packet with no further write; the first cycle after reset SHALL arbitrate from requester 0.
REQ-032 There SHALL be no other reset source and no asynchronous reset path.

Configuration
REQ-033 Macro FIFO_ARB_PKT_LOCK_EN SHALL select packet-locked arbitration.
REQ-034 With FIFO_ARB_PKT_LOCK_EN defined, BURST SHALL be left only on an accepted beat with req_last=1 (or reset).
REQ-035 With FIFO_ARB_PKT_LOCK_EN defined, MAX_BURST SHALL be ignored.
REQ-036 With FIFO_ARB_PKT_LOCK_EN defined, owner dropping req SHALL keep BURST and block all other requesters.
REQ-037 Without the macro, BURST SHALL also be left when an accepted beat makes beat_cnt reach MAX_BURST.
REQ-038 Without the macro, BURST SHALL also be left in any cycle with wfull=0 where owner has req=0; that cycle SHALL grant nobody.

Verification
REQ-039 req=4'b1111, all req_last=1, wfull=0, after reset -> gnt sequence 0001,0010,0100,1000,0001; waddr 0,1,2,3,4.
REQ-040 Requester 2 sends 6-beat packet, requester 0 req=1 constantly, macro off, MAX_BURST=4 -> 4 beats req2, 1 beat req0, 2 beats req2, and so on; with macro on -> 6 contiguous req2 beats.
REQ-041 Continuous writes, DEPTH=444 -> waddr 443 followed by 0, with no skipped address.
REQ-042 wfull=1 for 3 cycles mid-BURST -> gnt=0 and winc=0 for those cycles; beat_cnt, owner and waddr unchanged; transfer resumes on the following cycle.
REQ-043 wrst=1 after beat 2 of a locked packet from requester 3 -> next cycle gnt=0 and winc=0; after release, req=4'b1001 grants requester 0 first and waddr restarts at 0.
